// File: rtl/ad_array_sched.sv
// Sequencer for the absolute-difference systolic array: loads current-block rows,
// streams reference columns and tags each valid partial-SAD output with its candidate index.
module ad_array_sched #(
    parameter int unsigned EDGE_LEN    = 8,
    parameter int unsigned SEARCH_COLS = 32,
    parameter int unsigned PIPE_LAT    = 16,
    parameter int unsigned COL_W       = 5,
    parameter int unsigned ROW_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             cur_rd_en,
    output logic [ROW_W-1:0] cur_row,
    output logic             ref_rd_en,
    output logic [COL_W-1:0] ref_col,
    output logic             psad_valid,
    output logic [COL_W-1:0] cand_idx
);

    localparam int unsigned MAX_A   = (EDGE_LEN > SEARCH_COLS) ? EDGE_LEN : SEARCH_COLS;
    localparam int unsigned MAX_LEN = (MAX_A > PIPE_LAT) ? MAX_A : PIPE_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CUR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             flush;
    logic             busy_n, done_n, cur_rd_en_n, ref_rd_en_n;
    logic [ROW_W-1:0] cur_row_n;
    logic [COL_W-1:0] ref_col_n;

    logic             vld_in;
    logic [COL_W-1:0] tag_in;
    logic             vld_pipe [PIPE_LAT];
    logic [COL_W-1:0] tag_pipe [PIPE_LAT];

    // Next state, phase counter and the registered-output next values.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        flush   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_n = S_LOAD_CUR;
                    cnt_n   = '0;
                end
            end
            S_LOAD_CUR: begin
                if (cnt == CNT_W'(EDGE_LEN - 1)) begin
                    state_n = S_STREAM;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_STREAM: begin
                if (cnt == CNT_W'(SEARCH_COLS - 1)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(PIPE_LAT - 1)) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            flush   = 1'b1;
        end

        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DONE);
        cur_rd_en_n = (state_n == S_LOAD_CUR);
        ref_rd_en_n = (state_n == S_STREAM);
        cur_row_n   = cur_rd_en_n ? ROW_W'(cnt_n) : cur_row;
        ref_col_n   = ref_rd_en_n ? COL_W'(cnt_n) : ref_col;
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_rd_en <= 1'b0;
            cur_row   <= '0;
            ref_rd_en <= 1'b0;
            ref_col   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            done      <= done_n;
            cur_rd_en <= cur_rd_en_n;
            cur_row   <= cur_row_n;
            ref_rd_en <= ref_rd_en_n;
            ref_col   <= ref_col_n;
        end
    end

    // A column completes a candidate once the full block width has entered the array.
    assign vld_in = ref_rd_en && (ref_col >= COL_W'(EDGE_LEN - 1));
    assign tag_in = ref_col - COL_W'(EDGE_LEN - 1);

    // Tags only advance with a valid, so the last stage holds the most recent candidate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                tag_pipe[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
            end
        end else begin
            vld_pipe[0] <= vld_in;
            if (vld_in) begin
                tag_pipe[0] <= tag_in;
            end
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) begin
                    tag_pipe[i] <= tag_pipe[i-1];
                end
            end
        end
    end

    assign psad_valid = vld_pipe[PIPE_LAT-1];
    assign cand_idx   = tag_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_ad_array_sched.sv
// Scoreboard bench for ad_array_sched: default configuration plus a minimal
// SEARCH_COLS=EDGE_LEN=8, PIPE_LAT=1 instance sharing clock and reset.
module tb_ad_array_sched;

    localparam int S_CUR  = 0;
    localparam int S_REF  = 1;
    localparam int S_PSAD = 2;
    localparam int S_DONE = 3;
    localparam int S_PSB  = 4;
    localparam int S_DNB  = 5;
    localparam int NS     = 6;

    logic       clk = 1'b0;
    logic       rst, start, abort, start_b, abort_b;
    logic       busy, done, cur_rd_en, ref_rd_en, psad_valid;
    logic [2:0] cur_row;
    logic [4:0] ref_col, cand_idx;
    logic       busy_b, done_b, cur_rd_en_b, ref_rd_en_b, psad_valid_b;
    logic [2:0] cur_row_b;
    logic [4:0] ref_col_b, cand_idx_b;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int exp_c [NS][$];
    int exp_v [NS][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ad_array_sched u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .cur_rd_en(cur_rd_en), .cur_row(cur_row),
        .ref_rd_en(ref_rd_en), .ref_col(ref_col),
        .psad_valid(psad_valid), .cand_idx(cand_idx)
    );

    ad_array_sched #(
        .EDGE_LEN(8), .SEARCH_COLS(8), .PIPE_LAT(1), .COL_W(5), .ROW_W(3)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .cur_rd_en(cur_rd_en_b), .cur_row(cur_row_b),
        .ref_rd_en(ref_rd_en_b), .ref_col(ref_col_b),
        .psad_valid(psad_valid_b), .cand_idx(cand_idx_b)
    );

    task automatic check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_ev(int s, int c, int v);
        exp_c[s].push_back(c);
        exp_v[s].push_back(v);
    endtask

    task automatic observe(int s, int v, string name);
        int ec;
        int ev;
        if (exp_c[s].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected event value %0d at cycle %0d, none required", name, v, cyc);
        end else begin
            ec = exp_c[s].pop_front();
            ev = exp_v[s].pop_front();
            check({name, " cycle"}, cyc, ec);
            check({name, " value"}, v, ev);
        end
    endtask

    // Pass started by start sampled at cycle c0 on the default instance.
    task automatic push_pass(int c0, int n_ref, int n_psad, bit with_done);
        for (int i = 0; i < 8; i++) exp_ev(S_CUR, c0 + 1 + i, i);
        for (int j = 0; j < n_ref; j++) exp_ev(S_REF, c0 + 9 + j, j);
        for (int k = 0; k < n_psad; k++) exp_ev(S_PSAD, c0 + 32 + k, k);
        if (with_done) exp_ev(S_DONE, c0 + 57, 0);
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every strobe/valid/done the DUTs present is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (cur_rd_en)    observe(S_CUR, int'(cur_row), "cur_row");
            if (ref_rd_en)    observe(S_REF, int'(ref_col), "ref_col");
            if (psad_valid)   observe(S_PSAD, int'(cand_idx), "cand_idx");
            if (done)         observe(S_DONE, 0, "done");
            if (psad_valid_b) observe(S_PSB, int'(cand_idx_b), "cand_idx_b");
            if (done_b)       observe(S_DNB, 0, "done_b");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle busy", busy, 0);
        check("idle done", done, 0);
        check("idle cur_rd_en", cur_rd_en, 0);
        check("idle ref_rd_en", ref_rd_en, 0);
        check("idle psad_valid", psad_valid, 0);
        check("idle cur_row", cur_row, 0);
        check("idle ref_col", ref_col, 0);
        check("idle cand_idx", cand_idx, 0);
        check("idle busy_b", busy_b, 0);

        // Full pass on both instances
        c0 = cyc;
        start   = 1'b1;
        start_b = 1'b1;
        push_pass(c0, 32, 25, 1'b1);
        exp_ev(S_PSB, c0 + 17, 0);
        exp_ev(S_DNB, c0 + 18, 0);
        @(negedge clk);
        start   = 1'b0;
        start_b = 1'b0;
        check("pass busy rise", busy, 1);
        wait_cyc(c0 + 57);
        check("pass busy at done", busy, 1);
        wait_cyc(c0 + 58);
        check("pass busy fall", busy, 0);
        check("b busy after pass", busy_b, 0);
        repeat (4) @(negedge clk);

        // Start held over three back-to-back passes
        c0 = cyc;
        start = 1'b1;
        push_pass(c0, 32, 25, 1'b1);
        push_pass(c0 + 58, 32, 25, 1'b1);
        push_pass(c0 + 116, 32, 25, 1'b1);
        wait_cyc(c0 + 30);
        check("held busy mid", busy, 1);
        wait_cyc(c0 + 58);
        check("held idle gap 1", busy, 0);
        wait_cyc(c0 + 116);
        check("held idle gap 2", busy, 0);
        wait_cyc(c0 + 117);
        start = 1'b0;
        wait_cyc(c0 + 175);
        check("held final idle", busy, 0);
        repeat (4) @(negedge clk);

        // Abort in STREAM at ref_col 20, then a clean pass
        c0 = cyc;
        start = 1'b1;
        push_pass(c0, 21, 0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 29);
        check("abort at ref_col", ref_col, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort ref_rd_en", ref_rd_en, 0);
        check("abort psad_valid", psad_valid, 0);
        wait_cyc(c0 + 70);
        c1 = cyc;
        start = 1'b1;
        push_pass(c1, 32, 25, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c1 + 62);

        // Async reset mid-DRAIN
        c0 = cyc;
        start = 1'b1;
        push_pass(c0, 32, 14, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 45);
        #2 rst = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst psad_valid", psad_valid, 0);
        check("async rst cand_idx", cand_idx, 0);
        check("async rst ref_col", ref_col, 0);
        check("async rst done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("post rst busy", busy, 0);

        for (int s = 0; s < NS; s++) begin
            check($sformatf("leftover events stream %0d", s), exp_c[s].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ad_array_sched.md
Name: ad_array_sched

Overview:
- Sequencer for the absolute-difference systolic array.
- On a start request it loads the EDGE_LEN rows of the current block, then streams SEARCH_COLS reference columns into the array, one per cycle.
- It tracks the array pipeline latency and flags each cycle on which the array's partial-SAD batch output is a valid candidate, tagged with its horizontal index.
- It sits between the motion-estimation top-level control and the current/reference pixel buffers that feed the array.

Parameters:
- EDGE_LEN, 8, block edge length; the array is EDGE_LEN x EDGE_LEN.
- SEARCH_COLS, 32, reference columns streamed per search pass; must be >= EDGE_LEN.
- PIPE_LAT, 16, cycles from ref_rd_en for a column to the array output that column completes; must be >= 1.
- COL_W, 5, width of column and candidate indices; 2^COL_W >= SEARCH_COLS.
- ROW_W, 3, width of the current-row index; 2^ROW_W >= EDGE_LEN.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, request a search pass; sampled only in IDLE.
- abort, input, 1, synchronous cancel of the pass in progress.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a pass completes normally.
- cur_rd_en, output, 1, current-block row read strobe.
- cur_row, output, ROW_W, current-block row index.
- ref_rd_en, output, 1, reference column read strobe.
- ref_col, output, COL_W, reference column index.
- psad_valid, output, 1, array output this cycle is a valid candidate.
- cand_idx, output, COL_W, horizontal candidate index for psad_valid.

Behaviour:
- Reset values (rst low, asynchronous):
  - State is IDLE.
  - busy, done, cur_rd_en, ref_rd_en and psad_valid are 0.
  - cur_row, ref_col and cand_idx are 0.
  - The valid delay line is cleared.
- States: IDLE, LOAD_CUR, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 (with abort=0) moves to LOAD_CUR on the next edge.
  - start is ignored in every other state.
- LOAD_CUR:
  - Lasts exactly EDGE_LEN cycles.
  - cur_rd_en=1 throughout; cur_row counts 0..EDGE_LEN-1.
  - Moves to STREAM after row EDGE_LEN-1.
- STREAM:
  - Lasts exactly SEARCH_COLS cycles.
  - ref_rd_en=1 throughout; ref_col counts 0..SEARCH_COLS-1.
  - Moves to DRAIN after column SEARCH_COLS-1.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles.
  - ref_rd_en=0 and cur_rd_en=0.
- DONE:
  - Lasts 1 cycle; done=1; then moves to IDLE.
  - busy falls on the cycle after DONE.
- Valid tracking:
  - The delay line is PIPE_LAT deep. Its input is ref_rd_en AND (ref_col >= EDGE_LEN-1), plus the tag ref_col-(EDGE_LEN-1).
  - psad_valid(t) equals that input at cycle t-PIPE_LAT; cand_idx(t) is the matching tag.
  - When psad_valid=0, cand_idx holds its last value.
  - Each pass yields exactly SEARCH_COLS-EDGE_LEN+1 valid cycles, contiguous, with cand_idx 0,1,2,... incrementing by 1.
  - psad_valid may overlap STREAM when PIPE_LAT < SEARCH_COLS-EDGE_LEN+1. The last valid cycle is always the last DRAIN cycle.
- Total pass length: start sampled at cycle 0, done at cycle 1+EDGE_LEN+SEARCH_COLS+PIPE_LAT.
- Abort:
  - In any non-IDLE state, abort=1 moves to IDLE on the next edge.
  - It clears the delay line, so psad_valid is 0 from the next cycle.
  - All strobes go low; done is not asserted.
  - Abort in IDLE has no effect. Abort and start together in IDLE: abort wins and the pass does not start.
- Counters: cur_row and ref_col reset to 0 on entry to their state. No wrap-around is visible outside the state that owns the counter.
- Reset asserted mid-pass: immediate return to reset values; no done pulse.
- done and busy are registered outputs; none of the outputs has a combinational path from any input.

Test Plan:
- Reset with defaults: hold rst low 3 cycles, release, idle 5 cycles -> all outputs 0, busy=0, no strobes.
- Full pass with defaults: start pulse at cycle 0 ->
  - cur_rd_en cycles 1-8 with rows 0-7;
  - ref_rd_en cycles 9-40 with cols 0-31;
  - psad_valid cycles 32-56 (25 cycles) with cand_idx 0-24;
  - done only at cycle 57; busy high cycles 1-57.
- Start held high continuously over 3 passes -> passes back-to-back with one IDLE cycle between (cycles 58, 116); start during busy ignored; each pass repeats the timing above, offset by 58.
- Abort in STREAM at ref_col=20 -> next cycle IDLE; ref_rd_en=0; psad_valid=0 from the next cycle; no done; a new start then runs a clean full pass.
- SEARCH_COLS=EDGE_LEN=8, PIPE_LAT=1 -> exactly one valid cycle, cand_idx=0, on the single DRAIN cycle; done on the next cycle.
- Async reset asserted mid-DRAIN (rst low between clock edges) -> outputs at reset values immediately, without waiting for a clock edge; no done on release.
